// File: rtl/bit_serializer.sv
// bit_serializer: LSB-first parallel-to-serial transmitter with a one-word holding buffer.
// Defining BIT_SERIALIZER_PARITY_EN appends an even-parity bit to every word.
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             last,
    output logic             busy
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_SHIFT  = 2'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam logic [1:0]    S_PARITY = 2'd2;
`else
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_data;
    logic             r_data_valid;
    logic             r_last;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             r_par;
`endif
    logic             w_take;
    logic             w_word_end;
    logic             w_done;
    logic             w_load;
    logic [WIDTH-1:0] w_word;

    assign in_ready   = ~r_hold_full & ~rst;
    assign w_take     = in_valid & in_ready;
    // the payload MSB is on the output this cycle
    assign w_word_end = (r_state == S_SHIFT) & (r_cnt == LAST_CNT);
`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_done     = r_state == S_PARITY;
`else
    assign w_done     = w_word_end;
`endif
    // a word finishing can reload straight from the input when the buffer is empty, so no gap appears
    assign w_load     = ((r_state == S_IDLE) & r_hold_full) | (w_done & (r_hold_full | w_take));
    assign w_word     = r_hold_full ? r_hold : in_data;

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign last       = r_last;
    assign busy       = (r_state != S_IDLE) | r_hold_full;

    // Holding buffer payload: captured on every handshake
    always_ff @(posedge clk) begin
        if (w_take) r_hold <= in_data;
    end

    // Holding buffer occupancy: fills on handshake, empties when its word moves to the shift register
    always_ff @(posedge clk) begin
        if (rst) r_hold_full <= 1'b0;
        else     r_hold_full <= w_take ? ~w_load : (r_hold_full & ~w_load);
    end

    // Transmit FSM: bit0 is driven on the load edge itself, then one bit per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_data       <= IDLE_BIT;
            r_data_valid <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_load) begin
            r_state      <= S_SHIFT;
            r_shift      <= w_word >> 1;
            r_cnt        <= '0;
            r_data       <= w_word[0];
            r_data_valid <= 1'b1;
            r_last       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par        <= ^w_word;
`endif
        end else if (w_done) begin
            r_state      <= S_IDLE;
            r_data       <= IDLE_BIT;
            r_data_valid <= 1'b0;
            r_last       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        end else if (w_word_end) begin
            r_state      <= S_PARITY;
            r_data       <= r_par;
            r_last       <= 1'b1;
`endif
        end else if (r_state == S_SHIFT) begin
            r_shift      <= r_shift >> 1;
            r_cnt        <= r_cnt + 1'b1;
            r_data       <= r_shift[0];
`ifdef BIT_SERIALIZER_PARITY_EN
            r_last       <= 1'b0;
`else
            r_last       <= r_cnt == PRE_LAST;
`endif
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for bit_serializer; follows BIT_SERIALIZER_PARITY_EN when defined.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PW = W + PAR;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, data, data_valid, last, busy;
    logic         in_ready1, data1, data_valid1, last1, busy1;

    int         total = 0;
    int         bad = 0;
    int         vcount = 0;
    int         idle_run = 0;
    int         stall_lows = 0;
    bit         mon_en = 1'b0;
    logic [1:0] q[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .data_valid(data_valid), .last(last), .busy(busy)
    );

    bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) u_idle (
        .clk(clk), .rst(rst), .in_data(8'h00), .in_valid(1'b0), .in_ready(in_ready1),
        .data(data1), .data_valid(data_valid1), .last(last1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted word becomes W bits LSB first (plus parity), last on the final one
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] e;
            check("busy", busy, q.size() != 0);
            if (data_valid) begin
                vcount++;
                idle_run = 0;
                if (q.size() == 0) check("spurious_valid", data_valid, 1'b0);
                else begin
                    e = q.pop_front();
                    check("data", data, e[0]);
                    check("last", last, e[1]);
                end
            end else begin
                check("idle_data", data, 1'b0);
                check("idle_last", last, 1'b0);
                if (q.size() != 0) begin
                    idle_run++;
                    check("stall", idle_run > 1, 1'b0);
                end else idle_run = 0;
            end
            if (rst) begin
                q.delete();
                idle_run = 0;
            end else if (in_valid && in_ready) begin
                for (int i = 0; i < W; i++) q.push_back({PAR == 0 && i == W - 1, in_data[i]});
                if (PAR != 0) q.push_back({1'b1, ^in_data});
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            if (!in_ready) stall_lows++;
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) check("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_data", data, 1'b0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready_after", in_ready, 1'b1);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle1_data", data1, 1'b1);
            check("idle1_valid", data_valid1, 1'b0);
        end

        @(posedge clk);
        #1;
        send(8'hA5);
        in_valid = 1'b0;
        @(negedge clk);
        check("a5_latency", data_valid, 1'b0);
        for (int i = 0; i < PW; i++) begin
            @(negedge clk);
            check("a5_valid", data_valid, 1'b1);
            check("a5_last", last, i == PW - 1);
        end
        @(negedge clk);
        check("a5_end_valid", data_valid, 1'b0);
        check("a5_end_busy", busy, 1'b0);
        check("a5_end_data", data, 1'b0);

        @(posedge clk);
        #1;
        fork
            begin
                send(8'h01);
                send(8'h80);
                in_valid = 1'b0;
            end
            begin
                int run, n;
                logic [63:0] lm;
                run = 0;
                n = 0;
                lm = '0;
                while (!data_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                while (data_valid && run < 64) begin
                    if (last) lm[run] = 1'b1;
                    run++;
                    @(negedge clk);
                end
                check("b2b_run", run, 2 * PW);
                check("b2b_last_pos", lm, (64'd1 << (PW - 1)) | (64'd1 << (2 * PW - 1)));
            end
        join
        drain();

        @(posedge clk);
        #1;
        stall_lows = 0;
        send(8'h3C);
        send(8'hC3);
        send(8'h96);
        in_valid = 1'b0;
        check("bp_ready_dropped", stall_lows > 0, 1'b1);
        drain();

        @(posedge clk);
        #1;
        vcount = 0;
        send(8'hFF);
        send(8'h5A);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && vcount < 4; i++) @(negedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(negedge clk);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_data", data, 1'b0);
        check("midrst_valid", data_valid, 1'b0);
        check("midrst_last", last, 1'b0);
        check("midrst_busy0", busy, 1'b0);
        check("midrst_ready1", in_ready, 1'b1);
        repeat (3) @(negedge clk);

        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = W'($urandom);
            rst      = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
